// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch/sequencer stage feeding the decoder
//
// Holds the program counter. For each instruction it runs FETCH (read request
// to program memory), DECODE (one-cycle ID_CE strobe with INSTR stable) and
// EXEC (PC advances by one or jumps). With zero-wait memory it issues one
// instruction every three cycles. Every output comes from a register or is
// decoded from the state register.
//
// Optional feature macro: FETCH_TIMEOUT_EN. When it is defined, a FETCH that
// waits TIMEOUT_CYCLES cycles without MEM_VALID sets a sticky FETCH_ERR and
// returns to IDLE. IDLE then stays put until reset. When it is not defined,
// FETCH waits forever and FETCH_ERR is tied low.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   RUN        in   1 = keep fetching, 0 = stop after the current instruction
//   MEM_RE     out  program memory read request (high throughout FETCH)
//   MEM_ADDR   out  read address; equals PC during FETCH, otherwise held
//   MEM_RDATA  in   program memory read data
//   MEM_VALID  in   MEM_RDATA valid this cycle (looked at only in FETCH)
//   JMP_EN     in   take a jump at the end of EXEC
//   JMP_ADDR   in   jump target
//   INSTR      out  instruction register presented to the decoder
//   ID_CE      out  decoder enable, high for the single DECODE cycle
//   PC         out  current program counter
//   BUSY       out  high in any state other than IDLE
//   FETCH_ERR  out  sticky fetch-timeout flag
module instr_fetch_unit #(
  parameter int PC_WIDTH       = 4,
  parameter int INSTR_WIDTH    = 6,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   RUN,
  output logic                   MEM_RE,
  output logic [PC_WIDTH-1:0]    MEM_ADDR,
  input  logic [INSTR_WIDTH-1:0] MEM_RDATA,
  input  logic                   MEM_VALID,
  input  logic                   JMP_EN,
  input  logic [PC_WIDTH-1:0]    JMP_ADDR,
  output logic [INSTR_WIDTH-1:0] INSTR,
  output logic                   ID_CE,
  output logic [PC_WIDTH-1:0]    PC,
  output logic                   BUSY,
  output logic                   FETCH_ERR
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECODE = 2'd2,
    S_EXEC   = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [PC_WIDTH-1:0]    pc_q, pc_nxt, addr_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic                   timeout_hit;
  logic                   err_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  // This is the last permitted empty FETCH cycle. The counter would reach
  // TIMEOUT_CYCLES here, so FETCH gives up.
  assign timeout_hit = (state == S_FETCH) && !MEM_VALID &&
                       (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // The counter is held at zero outside FETCH. That clears it on every FETCH entry.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      to_cnt <= '0;
    end else if (state != S_FETCH) begin
      to_cnt <= '0;
    end else if (!MEM_VALID) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_q       = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (RUN && !err_q) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (MEM_VALID)        state_nxt = S_DECODE;
        else if (timeout_hit) state_nxt = S_IDLE;
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = RUN ? S_FETCH : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // The PC moves only at the end of EXEC. Sequential advance wraps modulo 2^PC_WIDTH.
  always_comb begin
    pc_nxt = pc_q;
    if (state == S_EXEC) begin
      pc_nxt = JMP_EN ? JMP_ADDR : pc_q + PC_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q    <= '0;
      instr_q <= '0;
      addr_q  <= '0;
    end else begin
      pc_q <= pc_nxt;
      if (state == S_FETCH && MEM_VALID) begin
        instr_q <= MEM_RDATA;
      end
      // Capture the address at FETCH entry. It then holds until the next fetch,
      // even though the PC advances when EXEC drops back to IDLE.
      if (state_nxt == S_FETCH && state != S_FETCH) begin
        addr_q <= pc_nxt;
      end
    end
  end

  // Output decode
  always_comb begin
    MEM_RE    = (state == S_FETCH);
    ID_CE     = (state == S_DECODE);
    BUSY      = (state != S_IDLE);
    MEM_ADDR  = addr_q;
    PC        = pc_q;
    INSTR     = instr_q;
    FETCH_ERR = err_q;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  localparam int PW = 4;
  localparam int IW = 6;
  localparam int TO = 8;
`ifdef FETCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          RUN = 1'b0;
  logic          MEM_RE;
  logic [PW-1:0] MEM_ADDR;
  logic [IW-1:0] MEM_RDATA = '0;
  logic          MEM_VALID = 1'b0;
  logic          JMP_EN = 1'b0;
  logic [PW-1:0] JMP_ADDR = '0;
  logic [IW-1:0] INSTR;
  logic          ID_CE;
  logic [PW-1:0] PC;
  logic          BUSY;
  logic          FETCH_ERR;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  instr_fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .RUN(RUN),
    .MEM_RE(MEM_RE), .MEM_ADDR(MEM_ADDR), .MEM_RDATA(MEM_RDATA), .MEM_VALID(MEM_VALID),
    .JMP_EN(JMP_EN), .JMP_ADDR(JMP_ADDR),
    .INSTR(INSTR), .ID_CE(ID_CE), .PC(PC), .BUSY(BUSY), .FETCH_ERR(FETCH_ERR)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Program memory responder: a configurable wait before each response, and optional junk valids outside FETCH.
  logic [IW-1:0] mem [16];
  int lat_cfg = 0;
  bit rand_lat = 0;
  bit stall = 0;
  bit spurious = 0;
  int wait_cnt = 0;
  bit prev_re = 0;

  always @(negedge CLK) begin
    if (MEM_RE === 1'b1) begin
      if (!prev_re) wait_cnt = rand_lat ? int'($urandom_range(0, 3)) : lat_cfg;
      if (!stall && wait_cnt == 0) begin
        MEM_VALID = 1'b1;
        MEM_RDATA = mem[MEM_ADDR];
      end else begin
        MEM_VALID = 1'b0;
        MEM_RDATA = IW'($urandom);
        if (wait_cnt > 0) wait_cnt--;
      end
    end else begin
      MEM_VALID = spurious ? 1'($urandom) : 1'b0;
      MEM_RDATA = IW'($urandom);
    end
    prev_re = (MEM_RE === 1'b1);
  end

  // Reference model. It tracks which part of the instruction life cycle is in progress, plus the architectural values.
  int            m_stage = 0;  // 0 idle, 1 waiting for memory, 2 decoder strobe, 3 executing
  int            m_wait = 0;
  bit            m_err = 0;
  logic [PW-1:0] m_pc, m_addr;
  logic [IW-1:0] m_instr;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_stage = 0; m_wait = 0; m_err = 0;
      m_pc = '0; m_addr = '0; m_instr = '0;
    end else begin
      case (m_stage)
        0: if (RUN && !m_err) begin m_stage = 1; m_wait = 0; m_addr = m_pc; end
        1: begin
          if (MEM_VALID) begin
            m_instr = MEM_RDATA;
            m_stage = 2;
          end else begin
            m_wait++;
            if (TO_EN && m_wait == TO) begin m_err = 1; m_stage = 0; end
          end
        end
        2: m_stage = 3;
        default: begin
          m_pc = JMP_EN ? JMP_ADDR : PW'((int'(m_pc) + 1) % (1 << PW));
          if (RUN) begin m_stage = 1; m_wait = 0; m_addr = m_pc; end
          else m_stage = 0;
        end
      endcase
    end
  end

  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      check("cycle_outputs",
            {MEM_RE, ID_CE, BUSY, FETCH_ERR, MEM_ADDR, PC, INSTR},
            {m_stage == 1, m_stage == 2, m_stage != 0, m_err, m_addr, m_pc, m_instr});
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic wait_idce(output int n);
    n = 0;
    do begin tick(); n++; end while (!ID_CE && n < 20);
    check("idce_seen", ID_CE, 1);
  endtask

  // Jump at the end of the next EXEC. Returns on the first FETCH cycle at the target.
  task automatic jump_next(input logic [PW-1:0] target);
    int n;
    wait_idce(n);
    tick();
    JMP_EN = 1'b1; JMP_ADDR = target;
    tick();
    JMP_EN = 1'b0; JMP_ADDR = PW'($urandom);
    check("jump_addr", MEM_ADDR, target);
  endtask

  initial begin
    int n, ce;
    logic [PW-1:0] a;
    for (int i = 0; i < 16; i++) mem[i] = IW'($urandom);
    mem[0] = 6'h01; mem[1] = 6'h22; mem[2] = 6'h3F;

    RST_N = 1'b0;
    repeat (2) tick();
    check("reset_state", {MEM_RE, ID_CE, BUSY, FETCH_ERR, MEM_ADDR, PC, INSTR}, 0);
    RST_N = 1'b1; RUN = 1'b1;

    // Zero-wait sequential run
    wait_idce(n);
    check("t1_latency", n, 2); check("t1_instr0", INSTR, 6'h01); check("t1_pc0", PC, 0);
    wait_idce(n);
    check("t1_period1", n, 3); check("t1_instr1", INSTR, 6'h22); check("t1_pc1", PC, 1);
    wait_idce(n);
    check("t1_period2", n, 3); check("t1_instr2", INSTR, 6'h3F); check("t1_pc2", PC, 2);
    tick(); tick();
    check("t1_pc3", PC, 3); check("t1_addr3", MEM_ADDR, 3); check("t1_re", MEM_RE, 1);

    // PC wrap from 15
    jump_next(4'd15);
    wait_idce(n); tick(); tick();
    check("t2_wrap_pc", PC, 0); check("t2_wrap_addr", MEM_ADDR, 0);

    // Jump taken in EXEC, ignored in DECODE
    jump_next(4'd2);
    jump_next(4'd9);
    jump_next(4'd2);
    wait_idce(n);
    JMP_EN = 1'b1; JMP_ADDR = 4'd9;
    tick();
    JMP_EN = 1'b0;
    tick();
    check("t4_decode_jmp_ignored", MEM_ADDR, 3);

    // Memory wait states on address 4
    lat_cfg = 3;
    jump_next(4'd4);
    n = 0;
    while (MEM_RE && n < 20) begin
      n++;
      check("t3_addr_hold", MEM_ADDR, 4);
      tick();
    end
    lat_cfg = 0;
    check("t3_re_cycles", n, 4); check("t3_idce", ID_CE, 1); check("t3_instr", INSTR, mem[4]);
    tick();
    check("t3_single_idce", ID_CE, 0);

    // RUN dropped mid-fetch, then reset mid-fetch
    lat_cfg = 2;
    jump_next(4'd5);
    RUN = 1'b0;
    wait_idce(n);
    check("t5_instr", INSTR, mem[5]);
    tick(); tick();
    lat_cfg = 0;
    check("t5_busy", BUSY, 0); check("t5_pc", PC, 6); check("t5_re", MEM_RE, 0);
    ce = 0;
    repeat (5) begin tick(); if (ID_CE) ce++; end
    check("t5_no_idce_idle", ce, 0);
    RUN = 1'b1; lat_cfg = 2;
    tick();
    check("t5_fetching", MEM_RE, 1);
    #2 RST_N = 1'b0;
    #1;
    check("t5_rst_re", MEM_RE, 0); check("t5_rst_pc", PC, 0); check("t5_rst_busy", BUSY, 0);
    RUN = 1'b0; spurious = 1;
    tick();
    RST_N = 1'b1; lat_cfg = 0;
    repeat (6) tick();
    check("t5_late_valid_ignored", BUSY, 0);
    spurious = 0;

`ifdef FETCH_TIMEOUT_EN
    stall = 1; RUN = 1'b1; a = PC;
    tick();
    n = 0; ce = 0;
    while (MEM_RE && n < 30) begin n++; if (ID_CE) ce++; tick(); end
    check("t6_fetch_cycles", n, TO); check("t6_err", FETCH_ERR, 1);
    check("t6_re", MEM_RE, 0); check("t6_pc", PC, a);
    repeat (10) begin tick(); if (BUSY || ID_CE) ce++; end
    check("t6_run_ignored", ce, 0);
    RST_N = 1'b0; stall = 0; RUN = 1'b0;
    tick();
    check("t6_err_cleared", FETCH_ERR, 0);
    RST_N = 1'b1;
`else
    stall = 1; RUN = 1'b1;
    tick();
    n = 0;
    repeat (20) begin if (MEM_RE && !FETCH_ERR) n++; tick(); end
    check("t6_waits_forever", n, 20);
    stall = 0;
    wait_idce(n);
`endif

    // Randomized run against the model
    rand_lat = 1; spurious = 1; RUN = 1'b1;
    repeat (1500) begin
      tick();
      RUN = ($urandom % 8) != 0;
      JMP_EN = ($urandom % 4) == 0;
      JMP_ADDR = PW'($urandom);
    end
    RUN = 1'b0; JMP_EN = 1'b0;
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch/sequencer stage directly upstream of the instruction decoder. Holds the program counter and reads 6-bit instructions from program memory over a request/valid handshake. Latches each instruction into an instruction register and drives INSTR plus a one-cycle ID_CE strobe into the decoder. Then advances the PC sequentially or by jump.

Parameters:
PC_WIDTH, 4, program counter / memory address width (16-word program space)
INSTR_WIDTH, 6, instruction width presented to decoder
TIMEOUT_CYCLES, 8, max FETCH wait cycles before error (only with FETCH_TIMEOUT_EN)

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
RUN  input  1  level; 1 = fetch/execute continuously, 0 = stop after current instruction
MEM_RE  output  1  program memory read request
MEM_ADDR  output  PC_WIDTH  program memory address (= PC while MEM_RE=1, else held)
MEM_RDATA  input  INSTR_WIDTH  program memory read data
MEM_VALID  input  1  MEM_RDATA valid this cycle
JMP_EN  input  1  take jump at end of current instruction (sampled in EXEC only)
JMP_ADDR  input  PC_WIDTH  jump target
INSTR  output  INSTR_WIDTH  instruction register to decoder
ID_CE  output  1  decoder enable strobe
PC  output  PC_WIDTH  current program counter
BUSY  output  1  1 in any state other than IDLE
FETCH_ERR  output  1  sticky fetch-timeout flag (tied 0 without FETCH_TIMEOUT_EN)

Behaviour:
- Reset (RST_N=0, async): state=IDLE, PC=0, INSTR=0, MEM_RE=0, MEM_ADDR=0, ID_CE=0, BUSY=0, FETCH_ERR=0, timeout counter=0.
- FSM states IDLE, FETCH, DECODE, EXEC. All outputs are registered or decoded from the state register; there is no combinational path from inputs to outputs.
- IDLE: if RUN=1, go to FETCH next cycle, else stay in IDLE.
- FETCH: MEM_RE=1, MEM_ADDR=PC. On the first cycle with MEM_VALID=1, INSTR<=MEM_RDATA and the next state is DECODE. MEM_VALID in the same cycle FETCH is entered is accepted (zero-wait memory). MEM_VALID outside FETCH is ignored.
- DECODE: exactly one cycle. ID_CE=1, INSTR stable. The decoder outputs are valid this cycle.
- EXEC: one cycle, ID_CE=0, INSTR held.
  - PC update: PC<=JMP_ADDR if JMP_EN=1, else PC<=PC+1 modulo 2^PC_WIDTH (wraps 15->0 at default).
  - Next state: FETCH if RUN=1, else IDLE.
- Throughput with zero-wait memory: one instruction per 3 cycles (FETCH, DECODE, EXEC). ID_CE period is 3.
- RUN deasserted mid-instruction: the current instruction completes through EXEC, the PC updates, then the FSM goes to IDLE. An instruction is never aborted.
- JMP_EN outside EXEC: ignored. JMP_ADDR equal to the current PC: legal, same instruction re-fetched.
- INSTR retains its last value in IDLE. ID_CE is never asserted outside DECODE.
- Reset mid-FETCH: MEM_RE drops immediately (async). A late MEM_VALID after reset release is ignored in IDLE.

Optional Feature:
Macro FETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on FETCH entry and increments each FETCH cycle without MEM_VALID.
  - If it reaches TIMEOUT_CYCLES, FETCH_ERR<=1 (sticky until reset), MEM_RE drops, state goes to IDLE, PC is unchanged, and no ID_CE is issued.
  - While FETCH_ERR=1, IDLE ignores RUN.
- Not defined: no counter, FETCH_ERR tied 0, FETCH waits indefinitely.

Test Plan:
1. Reset release, RUN=1, zero-wait memory with words 0x01,0x22,0x3F at addresses 0-2 -> INSTR=0x01,0x22,0x3F on successive DECODE cycles; ID_CE high 1 cycle of every 3; PC sequence 0,1,2,3.
2. PC=15, RUN=1, no jump -> after EXEC, PC=0 and MEM_ADDR=0 on next FETCH.
3. MEM_VALID delayed 3 cycles on address 4 -> MEM_RE high 4 cycles, MEM_ADDR=4 throughout, a single ID_CE pulse, INSTR=MEM_RDATA sampled on the valid cycle.
4. JMP_EN=1, JMP_ADDR=9 during EXEC at PC=2 -> next FETCH MEM_ADDR=9. The same JMP_EN pulse applied during DECODE -> ignored, next address 3.
5. RUN dropped during FETCH at PC=5 -> instruction completes (one ID_CE), PC=6, state IDLE, BUSY=0. RST_N pulsed low mid-FETCH -> PC=0 and MEM_RE=0 immediately.
6. FETCH_TIMEOUT_EN defined, MEM_VALID held 0 -> after 8 FETCH cycles FETCH_ERR=1, MEM_RE=0, PC unchanged, no ID_CE. RUN=1 has no effect until reset.
